// File: rtl/virtq_notify_sched.sv
// Turns virtqueue doorbell writes into one-at-a-time round-robin fetch requests, with a watchdog on each fetch.
// Build option: define VIRTQ_NOTIFY_COUNT_EN to add per-queue saturating counters of accepted notifies.
module virtq_notify_sched #(
  parameter int unsigned NUM_QUEUES     = 3,
  parameter int unsigned QIDX_W         = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TMO_W          = 13
) (
  input  logic                     clk,
  input  logic                     csr_rst,
  input  logic [NUM_QUEUES-1:0]    queue_ready,
  input  logic                     queue_notify_wr,
  input  logic [15:0]              queue_notify_idx,
  output logic                     fetch_req,
  output logic [QIDX_W-1:0]        fetch_qidx,
  input  logic                     fetch_ack,
  input  logic                     fetch_done,
  input  logic                     fetch_more,
  input  logic                     timeout_clr,
`ifdef VIRTQ_NOTIFY_COUNT_EN
  output logic [NUM_QUEUES*16-1:0] notify_cnt,
  input  logic                     notify_cnt_clr,
`endif
  output logic [NUM_QUEUES-1:0]    pending,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2
  } state_e;

  state_e                  state_q;
  logic                    fetch_req_q;
  logic [QIDX_W-1:0]       fetch_qidx_q;
  logic [QIDX_W-1:0]       last_grant_q;
  logic [TMO_W-1:0]        wd_q;
  logic                    busy_q;
  logic                    timeout_err_q;
  logic [NUM_QUEUES-1:0]   pending_q;
  logic [NUM_QUEUES-1:0]   pending_d;

  logic [NUM_QUEUES-1:0]   notify_set;
  logic [NUM_QUEUES-1:0]   more_set;
  logic [NUM_QUEUES-1:0]   ack_clr;
  logic [NUM_QUEUES-1:0]   eligible;
  logic                    cur_ready;
  logic                    ack_hit;
  logic                    done_hit;
  logic                    tmo_hit;
  logic                    grant_vld;
  logic [QIDX_W-1:0]       grant_idx;
  logic                    hi_vld;
  logic [QIDX_W-1:0]       hi_idx;
  logic [QIDX_W-1:0]       lo_idx;

  assign ack_hit  = (state_q == ST_REQ) && fetch_ack;
  assign done_hit = (state_q == ST_BUSY) && fetch_done;
  assign tmo_hit  = (state_q == ST_BUSY) && !fetch_done && (wd_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign eligible = pending_q & queue_ready;

  // Per-queue set/clear masks; set is applied after clear so a same-cycle notify survives.
  always_comb begin
    notify_set = '0;
    more_set   = '0;
    ack_clr    = '0;
    cur_ready  = 1'b0;
    for (int i = 0; i < int'(NUM_QUEUES); i++) begin
      if (queue_notify_wr && (queue_notify_idx == 16'(i)) && queue_ready[i]) notify_set[i] = 1'b1;
      if (fetch_qidx_q == QIDX_W'(i)) begin
        cur_ready  = queue_ready[i];
        ack_clr[i] = ack_hit;
        more_set[i] = done_hit && fetch_more;
      end
    end
    pending_d = ((pending_q & ~ack_clr) | notify_set | more_set) & queue_ready;
  end

  // Round-robin: lowest eligible index above last_grant, else lowest eligible overall.
  always_comb begin
    grant_vld = 1'b0;
    hi_vld    = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    for (int i = int'(NUM_QUEUES) - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_vld = 1'b1;
        lo_idx    = QIDX_W'(i);
        if (QIDX_W'(i) > last_grant_q) begin
          hi_vld = 1'b1;
          hi_idx = QIDX_W'(i);
        end
      end
    end
    grant_idx = hi_vld ? hi_idx : lo_idx;
  end

  always_ff @(posedge clk or posedge csr_rst) begin
    if (csr_rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk or posedge csr_rst) begin
    if (csr_rst) begin
      state_q       <= ST_IDLE;
      fetch_req_q   <= 1'b0;
      fetch_qidx_q  <= '0;
      last_grant_q  <= QIDX_W'(NUM_QUEUES - 1);
      wd_q          <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= tmo_hit || (timeout_err_q && !timeout_clr);
      case (state_q)
        ST_IDLE: begin
          if (grant_vld) begin
            fetch_req_q  <= 1'b1;
            fetch_qidx_q <= grant_idx;
            busy_q       <= 1'b1;
            state_q      <= ST_REQ;
          end
        end
        ST_REQ: begin
          // An accepted request always proceeds; a withdrawn queue only aborts an unaccepted one.
          if (fetch_ack) begin
            fetch_req_q <= 1'b0;
            wd_q        <= '0;
            state_q     <= ST_BUSY;
          end else if (!cur_ready) begin
            fetch_req_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (fetch_done || tmo_hit) begin
            last_grant_q <= fetch_qidx_q;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end else begin
            wd_q <= wd_q + TMO_W'(1);
          end
        end
        default: begin
          fetch_req_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef VIRTQ_NOTIFY_COUNT_EN
  logic [NUM_QUEUES*CNT_W-1:0] notify_cnt_q;

  // Saturating accepted-notify counters; clear has priority over increment.
  always_ff @(posedge clk or posedge csr_rst) begin
    if (csr_rst) begin
      notify_cnt_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_QUEUES); i++) begin
        if (notify_cnt_clr) begin
          notify_cnt_q[CNT_W*i +: CNT_W] <= '0;
        end else if (notify_set[i] && (notify_cnt_q[CNT_W*i +: CNT_W] != {CNT_W{1'b1}})) begin
          notify_cnt_q[CNT_W*i +: CNT_W] <= notify_cnt_q[CNT_W*i +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

  assign notify_cnt = notify_cnt_q;
`endif

  assign fetch_req   = fetch_req_q;
  assign fetch_qidx  = fetch_qidx_q;
  assign pending     = pending_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_virtq_notify_sched.sv
// Directed bench for virtq_notify_sched: expected grant order is queued by stimulus and
// checked by a monitor on every new fetch request; state outputs are checked inline.
module tb_virtq_notify_sched;

  localparam int unsigned NQ  = 3;
  localparam int unsigned QW  = 2;
  localparam int unsigned TMO = 16;

  logic          clk = 1'b0;
  logic          csr_rst;
  logic [NQ-1:0] queue_ready;
  logic          queue_notify_wr;
  logic [15:0]   queue_notify_idx;
  logic          fetch_req;
  logic [QW-1:0] fetch_qidx;
  logic          fetch_ack;
  logic          fetch_done;
  logic          fetch_more;
  logic          timeout_clr;
  logic [NQ-1:0] pending;
  logic          busy;
  logic          timeout_err;
`ifdef VIRTQ_NOTIFY_COUNT_EN
  logic [NQ*16-1:0] notify_cnt;
  logic             notify_cnt_clr = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  logic prev_req = 1'b0;

  virtq_notify_sched #(
    .NUM_QUEUES(NQ), .QIDX_W(QW), .TIMEOUT_CYCLES(TMO), .TMO_W(5)
  ) dut (
    .clk(clk), .csr_rst(csr_rst), .queue_ready(queue_ready),
    .queue_notify_wr(queue_notify_wr), .queue_notify_idx(queue_notify_idx),
    .fetch_req(fetch_req), .fetch_qidx(fetch_qidx), .fetch_ack(fetch_ack),
    .fetch_done(fetch_done), .fetch_more(fetch_more), .timeout_clr(timeout_clr),
`ifdef VIRTQ_NOTIFY_COUNT_EN
    .notify_cnt(notify_cnt), .notify_cnt_clr(notify_cnt_clr),
`endif
    .pending(pending), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Monitor: every rising fetch_req must match the next expected grant.
  always @(negedge clk) begin
    if (fetch_req === 1'b1 && prev_req !== 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL grant_unexpected: qidx=%0d, required no request", fetch_qidx);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(fetch_qidx) != e) begin
          n_fail++;
          $display("FAIL grant_order: qidx=%0d, required %0d", fetch_qidx, e);
        end
      end
    end
    prev_req = fetch_req;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic notify(input int idx);
    queue_notify_wr  = 1'b1;
    queue_notify_idx = 16'(idx);
    step();
    queue_notify_wr  = 1'b0;
  endtask

  task automatic wait_req();
    int w;
    w = 0;
    while (fetch_req !== 1'b1 && w < 40) begin
      step();
      w++;
    end
    chk("req_wait", 32'(fetch_req), 32'd1);
  endtask

  task automatic do_done(input logic more);
    fetch_done = 1'b1;
    fetch_more = more;
    step();
    fetch_done = 1'b0;
    fetch_more = 1'b0;
  endtask

  // Wait for request, ack at once, stay BUSY n cycles, then finish.
  task automatic serve(input int n, input logic more);
    wait_req();
    fetch_ack = 1'b1;
    step();
    fetch_ack = 1'b0;
    repeat (n) step();
    do_done(more);
  endtask

  // As serve with 5 BUSY cycles, notifying each queue in mask during the first three.
  task automatic serve_notify(input logic [2:0] mask, input logic more);
    wait_req();
    fetch_ack = 1'b1;
    step();
    fetch_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      queue_notify_wr  = (i < 3) && mask[i];
      queue_notify_idx = 16'(i);
      step();
    end
    queue_notify_wr = 1'b0;
    do_done(more);
  endtask

  initial begin
    csr_rst = 1'b1;
    queue_ready = 3'b111;
    queue_notify_wr = 1'b0;
    queue_notify_idx = '0;
    fetch_ack = 1'b0;
    fetch_done = 1'b0;
    fetch_more = 1'b0;
    timeout_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 csr_rst = 1'b0;
    step();
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_req", 32'(fetch_req), 32'd0);
    chk("rst_qidx", 32'(fetch_qidx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);

    // Single notify latency and handshake.
    exp_q.push_back(1);
    notify(1);
    chk("t1_pending", 32'(pending), 32'b010);
    chk("t1_req_early", 32'(fetch_req), 32'd0);
    step();
    chk("t1_req", 32'(fetch_req), 32'd1);
    chk("t1_qidx", 32'(fetch_qidx), 32'd1);
    fetch_ack = 1'b1;
    step();
    fetch_ack = 1'b0;
    chk("t1_pend_clr", 32'(pending), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_req_drop", 32'(fetch_req), 32'd0);
    do_done(1'b0);
    chk("t1_idle", 32'(busy), 32'd0);

    // last_grant=1: serve 2 alone, all three notified while BUSY -> 0,1,2.
    exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    notify(2);
    serve_notify(3'b111, 1'b0);
    chk("rr_pending", 32'(pending), 32'b111);
    serve(5, 1'b0); serve(5, 1'b0); serve(5, 1'b0);

    // last_grant=2: serve 1, then all pending with last_grant=1 -> 2,0,1.
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(1);
    notify(1);
    serve_notify(3'b111, 1'b0);
    serve(5, 1'b0); serve(5, 1'b0); serve(5, 1'b0);

    // fetch_more re-arms queue 0 behind 1 and 2; then ack + notify same cycle keeps pending.
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(0);
    notify(0);
    serve_notify(3'b110, 1'b1);
    chk("more_pending", 32'(pending), 32'b111);
    serve(5, 1'b0); serve(5, 1'b0);
    wait_req();
    fetch_ack = 1'b1;
    queue_notify_wr = 1'b1;
    queue_notify_idx = 16'd0;
    step();
    fetch_ack = 1'b0;
    queue_notify_wr = 1'b0;
    chk("set_wins_pending", 32'(pending), 32'b001);
    chk("set_wins_busy", 32'(busy), 32'd1);
    repeat (5) step();
    do_done(1'b0);
    serve(5, 1'b0);

    // Ignored notifies: not-ready queue and out-of-range indices.
    queue_ready = 3'b011;
    notify(2); notify(5); notify(3);
    repeat (3) step();
    chk("ign_pending", 32'(pending), 32'd0);
    chk("ign_req", 32'(fetch_req), 32'd0);
    queue_ready = 3'b111;

    // queue_ready drop during REQ withdraws the request.
    exp_q.push_back(1);
    notify(1);
    wait_req();
    queue_ready = 3'b101;
    step();
    chk("drop_req", 32'(fetch_req), 32'd0);
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_pending", 32'(pending), 32'd0);
    queue_ready = 3'b111;
    repeat (3) step();
    chk("drop_no_rereq", 32'(fetch_req), 32'd0);

    // queue_ready drop during BUSY only clears pending.
    exp_q.push_back(2);
    notify(2);
    wait_req();
    fetch_ack = 1'b1;
    step();
    fetch_ack = 1'b0;
    notify(2);
    chk("busy_renotify", 32'(pending), 32'b100);
    queue_ready = 3'b011;
    step();
    chk("busydrop_pending", 32'(pending), 32'd0);
    chk("busydrop_busy", 32'(busy), 32'd1);
    queue_ready = 3'b111;
    repeat (2) step();
    do_done(1'b0);
    chk("busydrop_idle", 32'(busy), 32'd0);

    // Watchdog: 16 BUSY cycles without done, then queue 0 is granted.
    exp_q.push_back(1); exp_q.push_back(0);
    notify(1);
    wait_req();
    fetch_ack = 1'b1;
    step();
    fetch_ack = 1'b0;
    notify(0);
    repeat (14) step();
    chk("wd_not_yet", 32'(timeout_err), 32'd0);
    chk("wd_still_busy", 32'(busy), 32'd1);
    step();
    chk("wd_tmo", 32'(timeout_err), 32'd1);
    chk("wd_idle", 32'(busy), 32'd0);
    chk("wd_pending", 32'(pending), 32'b001);
    step();
    chk("wd_next_req", 32'(fetch_req), 32'd1);
    chk("wd_next_qidx", 32'(fetch_qidx), 32'd0);
    chk("wd_sticky", 32'(timeout_err), 32'd1);
    fetch_ack = 1'b1;
    timeout_clr = 1'b1;
    step();
    fetch_ack = 1'b0;
    timeout_clr = 1'b0;
    chk("wd_clr", 32'(timeout_err), 32'd0);
    repeat (3) step();
    do_done(1'b0);

    // Asynchronous reset in the middle of BUSY.
    exp_q.push_back(1); exp_q.push_back(0);
    notify(1);
    wait_req();
    fetch_ack = 1'b1;
    step();
    fetch_ack = 1'b0;
    notify(2);
    #2 csr_rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_pending", 32'(pending), 32'd0);
    chk("arst_req", 32'(fetch_req), 32'd0);
    chk("arst_qidx", 32'(fetch_qidx), 32'd0);
    @(posedge clk);
    #3 csr_rst = 1'b0;
    step();
    notify(0);
    step();
    chk("post_rst_qidx", 32'(fetch_qidx), 32'd0);
    serve(3, 1'b0);

    repeat (3) step();
    chk("exp_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/virtq_notify_sched.md
Name: virtq_notify_sched

Overview:
- Schedules virtqueue service for the avail-ring fetch engine.
- Records queue_notify doorbell writes from the virtio CSR block as per-queue pending bits.
- Arbitrates round-robin among pending, ready queues and issues one fetch request at a time.
- Re-arms a queue when the fetch engine reports more avail entries, and guards each fetch with a watchdog.

Parameters:
- NUM_QUEUES, 3, number of virtqueues (2..8)
- QIDX_W, 2, width of queue index, equal to clog2(NUM_QUEUES)
- TIMEOUT_CYCLES, 4096, maximum BUSY cycles before watchdog release (at least 2)
- TMO_W, 13, width of the watchdog counter; must hold TIMEOUT_CYCLES

Ports:
- clk  in  1  clock, shared with the CSR block
- csr_rst  in  1  reset, asynchronous, active-high
- queue_ready  in  NUM_QUEUES  per-queue QUEUE_READY from CSR
- queue_notify_wr  in  1  single-cycle strobe, CSR write to QUEUE_NOTIFY
- queue_notify_idx  in  16  written notify value (queue index)
- fetch_req  out  1  request to fetch engine
- fetch_qidx  out  QIDX_W  queue being requested/serviced
- fetch_ack  in  1  engine accepted request
- fetch_done  in  1  single-cycle pulse, engine finished the current queue
- fetch_more  in  1  qualifies fetch_done: avail entries remain
- timeout_clr  in  1  clears timeout_err
- pending  out  NUM_QUEUES  pending-notify bits, registered
- busy  out  1  high in REQ or BUSY
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (async assert, sync release):
  - pending=0, fetch_req=0, fetch_qidx=0, busy=0, timeout_err=0.
  - last_grant=NUM_QUEUES-1, so queue 0 wins first. State=IDLE. Watchdog counter=0.
- Pending set/clear:
  - pending[i] sets on queue_notify_wr with queue_notify_idx==i and queue_ready[i]=1.
  - idx>=NUM_QUEUES is ignored. A notify to a not-ready queue is ignored.
  - pending[i] is forced 0 whenever queue_ready[i]=0.
  - Set wins over clear in the same cycle (ack or done-clear plus notify → stays 1).
- State machine (IDLE, REQ, BUSY):
  - IDLE: eligible = pending & queue_ready. If nonzero, pick the first eligible index scanning upward from last_grant+1 with wrap. Register fetch_qidx=q, fetch_req=1, go REQ the next cycle.
  - REQ: fetch_req and fetch_qidx are held stable until fetch_ack.
    - On ack: fetch_req=0, clear pending[q] (unless a same-cycle notify), go BUSY, watchdog=0.
    - If queue_ready[q] falls before ack: fetch_req=0, go IDLE, last_grant unchanged.
  - BUSY: watchdog increments each cycle. fetch_ack is ignored here.
    - On fetch_done: if fetch_more, set pending[q]. last_grant=q, go IDLE.
    - If watchdog reaches TIMEOUT_CYCLES-1 without done: timeout_err=1, last_grant=q, pending[q] kept as is, go IDLE.
    - queue_ready falling in BUSY does not abort; it only clears pending.
- Latency: notify at cycle N → pending visible N+1 → fetch_req asserted N+2. Back-to-back service gives a minimum 1 IDLE cycle between done and the next fetch_req.
- fetch_done in IDLE or REQ is ignored.
- timeout_err clears on timeout_clr. If a new timeout coincides with timeout_clr, timeout_err stays 1.
- busy = (state != IDLE), registered with state.
- Outputs are glitch-free registers. No combinational path from any input to fetch_req.

Optional Feature:
- Macro: VIRTQ_NOTIFY_COUNT_EN.
- Defined:
  - Adds output notify_cnt (NUM_QUEUES*16 bits, queue i at [16i+15:16i]): saturating count of accepted notifies per queue.
  - Adds input notify_cnt_clr (1 bit), which zeroes all counters; clear wins over increment.
  - Counters reset to 0. A notify that merges into an already-set pending bit still counts.
- Undefined: no extra ports or logic; everything else is identical.

Test Plan:
- Reset then notify idx=1 with queue_ready=3'b111 → pending=3'b010 one cycle later, fetch_req=1 with qidx=1 two cycles after the notify. Ack → pending=0, busy=1. done (more=0) → busy=0 next cycle.
- Notify all three queues in the same idle window, ack immediately, done after 5 cycles each → grant order 0,1,2. Repeat with last_grant=1 → order 2,0,1.
- Queue 0 in BUSY, notify idx=0 again, then done with fetch_more=1 → pending[0]=1 and queue 0 is re-requested after queues 1/2 if those are pending.
- Notify idx=2 with queue_ready[2]=0, and notify idx=5 → pending stays 0, fetch_req never asserts. Drop queue_ready[1] during REQ for q1 → fetch_req=0 next cycle, state IDLE.
- TIMEOUT_CYCLES=16, ack but never done → timeout_err=1 after 16 BUSY cycles and the next pending queue is granted. timeout_clr → timeout_err=0.
- Assert csr_rst mid-BUSY → all outputs 0 immediately (async). After release, a notify to idx=0 is served first.
